serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: request to begin an addition, sampled on the rising edge of clk.
REQ-005 Port a, input, WIDTH bits: first operand, captured when start is accepted.
REQ-006 Port b, input, WIDTH bits: second operand, captured when start is accepted.
REQ-007 Port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 Port busy, output, 1 bit: high while an addition is in progress.
REQ-009 Port done, output, 1 bit: a one-cycle pulse marking completion.
REQ-010 Port sum, output, WIDTH bits: registered result, equal to (a+b+cin) mod 2^WIDTH.
REQ-011 Port cout, output, 1 bit: registered carry-out of the last addition.

Function
REQ-012 The block SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture a, b and cin into internal shift/carry registers, clear the bit counter, and move to RUN.
REQ-014 In RUN, each clock edge SHALL process exactly one bit, LSB first, using full-adder logic:
- s = a_i ^ b_i ^ c
- c_next = a_i&b_i | b_i&c | a_i&c
REQ-015 In RUN, each edge SHALL shift the operand registers right by one and shift s into the MSB of an internal result register.
REQ-016 The bit counter SHALL increment once per RUN edge; the edge that processes bit WIDTH-1 SHALL move the state to DONE.
REQ-017 On that final RUN edge, sum SHALL load the complete result and cout SHALL load the final carry.
REQ-018 sum and cout SHALL change only on the final RUN edge and on reset; they SHALL hold their value through IDLE, RUN and DONE.
REQ-019 Latency: with start sampled at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH.
REQ-020 busy SHALL be high exactly while the state is RUN, i.e. for WIDTH cycles.
REQ-021 done SHALL be high exactly while the state is DONE, i.e. for one cycle.
REQ-022 From DONE, start=1 SHALL be accepted exactly as in IDLE (back-to-back operation, one idle-free turnaround); start=0 SHALL return the state to IDLE.
REQ-023 start=1 while in RUN SHALL be ignored: operands, counter and carry are unaffected.
REQ-024 Changes on a, b or cin while in RUN SHALL not affect the result in progress.
REQ-025 When WIDTH=1, RUN SHALL last one cycle and the result SHALL match the full-adder truth table.
REQ-026 The bit counter SHALL be wide enough to count to WIDTH without wrap-around.

Reset
REQ-027 While rst=1 at a clock edge, the state SHALL become IDLE and busy, done, sum, cout, the counter, the carry and the shift registers SHALL all become 0.
REQ-028 rst SHALL take priority over start in every state.
REQ-029 rst asserted during RUN SHALL abort the operation with no done pulse and sum=0, cout=0.
REQ-030 The first start accepted after rst deasserts SHALL operate normally.

Verification
REQ-031 WIDTH=8, a=0xFF, b=0x01, cin=0, start pulsed at edge k -> busy high for 8 cycles, done high only after edge k+8, sum=0x00, cout=1.
REQ-032 WIDTH=8, a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; then immediately a=0x12, b=0x34, cin=0 with start held during DONE -> sum=0x46, cout=0, no idle cycle between the two operations.
REQ-033 WIDTH=8, start=1 re-pulsed with a=0xFF, b=0xFF at cycle 3 of a run of 0x03+0x04 -> the request is ignored and the result is sum=0x07, cout=0 at the original done time.
REQ-034 WIDTH=8, rst asserted at cycle 4 of a run -> next cycle state IDLE, busy=0, sum=0x00, cout=0, and no done pulse follows.
REQ-035 WIDTH=1, all 8 combinations of {a,b,cin} -> {cout,sum} equals a+b+cin, with done 1 cycle after each start.
REQ-036 WIDTH=8, a changed every cycle during RUN for 0x0F+0xF0 (cin=0) -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, LSB first.
// Operands are captured on start; sum/cout are registered and update only at completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must reach WIDTH itself, hence WIDTH+1 in the log.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             s_s;
    logic             c_next_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;

    // Full-adder step on the current LSBs and the result register shifted in from the MSB.
    always_comb begin
        s_s        = a_r[0] ^ b_r[0] ^ carry_r;
        c_next_s   = (a_r[0] & b_r[0]) | (b_r[0] & carry_r) | (a_r[0] & carry_r);
        res_next_s = res_r >> 1;
        res_next_s[WIDTH-1] = s_s;
        if (cnt_r == LAST_BIT) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Control FSM and datapath registers; start is only honoured in IDLE or DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        res_r   <= '0;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    carry_r <= c_next_s;
                    res_r   <= res_next_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        sum_r   <= res_next_s;
                        cout_r  <= c_next_s;
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit and a 1-bit instance sharing clock and reset.
module tb_serial_adder;

    logic       clk_s;
    logic       rst_s;
    logic       start_s;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic       cin_s;
    logic       busy_s;
    logic       done_s;
    logic [7:0] sum_s;
    logic       cout_s;

    logic       start1_s;
    logic [0:0] a1_s;
    logic [0:0] b1_s;
    logic       cin1_s;
    logic       busy1_s;
    logic       done1_s;
    logic [0:0] sum1_s;
    logic       cout1_s;

    int         checks;
    int         errors;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk_s), .rst(rst_s), .start(start_s), .a(a_s), .b(b_s), .cin(cin_s),
        .busy(busy_s), .done(done_s), .sum(sum_s), .cout(cout_s)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk_s), .rst(rst_s), .start(start1_s), .a(a1_s), .b(b1_s), .cin(cin1_s),
        .busy(busy1_s), .done(done1_s), .sum(sum1_s), .cout(cout1_s)
    );

    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    // Present operands with start for exactly one edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a_s     = av;
        b_s     = bv;
        cin_s   = cv;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
    endtask

    // Called right after the accepting edge. mode 1: re-pulse start at RUN cycle 3; mode 2: churn a.
    task automatic run_body(input logic [7:0] exp_sum, input logic exp_cout, input int mode,
                            input bit idle_after, input string name);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy_s !== 1'b1 || done_s !== 1'b0) begin
                errors++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b, want busy=1 done=0", name, i, busy_s, done_s);
            end
            checks++;
            if (sum_s !== last_sum || cout_s !== last_cout) begin
                errors++;
                $display("FAIL %s hold cycle %0d: sum=%h cout=%b, want sum=%h cout=%b",
                         name, i, sum_s, cout_s, last_sum, last_cout);
            end
            if (mode == 1 && i == 2) begin
                start_s = 1'b1;
                a_s     = 8'hFF;
                b_s     = 8'hFF;
                cin_s   = 1'b1;
            end else begin
                start_s = 1'b0;
            end
            if (mode == 2) begin
                a_s = 8'(i * 37 + 5);
            end
            tick();
        end
        start_s = 1'b0;
        checks++;
        if (done_s !== 1'b1 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL %s completion: done=%b busy=%b, want done=1 busy=0", name, done_s, busy_s);
        end
        checks++;
        if (sum_s !== exp_sum || cout_s !== exp_cout) begin
            errors++;
            $display("FAIL %s result: sum=%h cout=%b, want sum=%h cout=%b", name, sum_s, cout_s, exp_sum, exp_cout);
        end
        last_sum  = exp_sum;
        last_cout = exp_cout;
        if (idle_after) begin
            tick();
            checks++;
            if (done_s !== 1'b0 || busy_s !== 1'b0 || sum_s !== last_sum || cout_s !== last_cout) begin
                errors++;
                $display("FAIL %s after done: done=%b busy=%b sum=%h cout=%b, want 0 0 %h %b",
                         name, done_s, busy_s, sum_s, cout_s, last_sum, last_cout);
            end
        end
    endtask

    task automatic test_reset();
        rst_s = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;
        checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || sum_s !== 8'h00 || cout_s !== 1'b0) begin
            errors++;
            $display("FAIL reset w8: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy_s, done_s, sum_s, cout_s);
        end
        checks++;
        if (busy1_s !== 1'b0 || done1_s !== 1'b0 || sum1_s !== 1'b0 || cout1_s !== 1'b0) begin
            errors++;
            $display("FAIL reset w1: busy=%b done=%b sum=%b cout=%b, want 0 0 0 0", busy1_s, done1_s, sum1_s, cout1_s);
        end
        last_sum  = 8'h00;
        last_cout = 1'b0;
    endtask

    task automatic test_basic();
        start_op(8'hFF, 8'h01, 1'b0);
        run_body(8'h00, 1'b1, 0, 1'b1, "ff_plus_01");
        start_op(8'h3C, 8'h81, 1'b1);
        run_body(8'hBE, 1'b0, 0, 1'b1, "3c_plus_81_c1");
    endtask

    task automatic test_back_to_back();
        start_op(8'hA5, 8'h5A, 1'b1);
        run_body(8'h00, 1'b1, 0, 1'b0, "a5_plus_5a_c1");
        start_op(8'h12, 8'h34, 1'b0);
        run_body(8'h46, 1'b0, 0, 1'b1, "b2b_12_plus_34");
    endtask

    task automatic test_ignore_start();
        start_op(8'h03, 8'h04, 1'b0);
        run_body(8'h07, 1'b0, 1, 1'b1, "restart_ignored");
    endtask

    task automatic test_input_change();
        start_op(8'h0F, 8'hF0, 1'b0);
        run_body(8'hFF, 1'b0, 2, 1'b1, "inputs_churn");
    endtask

    task automatic test_reset_abort();
        start_op(8'h0F, 8'h01, 1'b0);
        tick();
        tick();
        tick();
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || sum_s !== 8'h00 || cout_s !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy_s, done_s, sum_s, cout_s);
        end
        last_sum  = 8'h00;
        last_cout = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (done_s !== 1'b0 || busy_s !== 1'b0) begin
                errors++;
                $display("FAIL abort quiet cycle %0d: done=%b busy=%b, want 0 0", i, done_s, busy_s);
            end
        end
        start_op(8'h12, 8'h34, 1'b1);
        run_body(8'h47, 1'b0, 0, 1'b1, "after_reset");
    endtask

    task automatic test_width1();
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            logic [1:0] want;
            vec      = 3'(v);
            a1_s     = vec[2];
            b1_s     = vec[1];
            cin1_s   = vec[0];
            want     = {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
            start1_s = 1'b1;
            tick();
            start1_s = 1'b0;
            checks++;
            if (busy1_s !== 1'b1 || done1_s !== 1'b0) begin
                errors++;
                $display("FAIL w1 run abc=%b: busy=%b done=%b, want 1 0", vec, busy1_s, done1_s);
            end
            tick();
            checks++;
            if (done1_s !== 1'b1 || busy1_s !== 1'b0 || {cout1_s, sum1_s} !== want) begin
                errors++;
                $display("FAIL w1 result abc=%b: done=%b busy=%b cout_sum=%b%b, want 1 0 %b",
                         vec, done1_s, busy1_s, cout1_s, sum1_s, want);
            end
            tick();
            checks++;
            if (done1_s !== 1'b0) begin
                errors++;
                $display("FAIL w1 pulse abc=%b: done=%b, want 0", vec, done1_s);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_s    = 1'b0;
        start_s  = 1'b0;
        a_s      = 8'h00;
        b_s      = 8'h00;
        cin_s    = 1'b0;
        start1_s = 1'b0;
        a1_s     = 1'b0;
        b1_s     = 1'b0;
        cin1_s   = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_input_change();
        test_reset_abort();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
